adc_spi_reader: RTL and testbench

- Responder end of the ADC trigger/done handshake issued by the sampling controller.
- On each trigger, pulses the AD_CONV input of the LTC1407A dual ADC and clocks out one 34-bit SPI frame.
- Extracts the two 14-bit two's-complement samples, presents them, and returns a one-cycle done.
- Sits between the sampling controller and the board ADC pins, in the same clock domain as the controller.

---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_spi_reader_if.sv | 27 ++
 rtl/spi_sck_gen.sv | 46 ++++
 rtl/adc_spi_reader.sv | 137 +++++++++++++
 tb/tb_adc_spi_reader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the LTC1407A SPI frame reader.
package adc_pkg;

    localparam int FRAME_BITS = 34;
    localparam int SAMPLE_W   = 14;
    localparam int A_FIRST    = 2;
    localparam int B_FIRST    = 18;
    localparam int BIT_CNT_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

endpackage

// File: rtl/adc_spi_reader_if.sv
// Trigger/done handshake between the sampling controller and the ADC reader.
interface adc_spi_reader_if;
    import adc_pkg::*;

    logic                adc_trig;
    logic                adc_done;
    logic [SAMPLE_W-1:0] adc_a;
    logic [SAMPLE_W-1:0] adc_b;
    logic                busy;

    modport master (
        output adc_trig,
        input  adc_done,
        input  adc_a,
        input  adc_b,
        input  busy
    );

    modport slave (
        input  adc_trig,
        output adc_done,
        output adc_a,
        output adc_b,
        output busy
    );

endinterface

// File: rtl/spi_sck_gen.sv
// SCK divider: low for CLKDIV cycles then high for CLKDIV cycles while enabled.
// rise_tick/fall_tick flag the clk edge on which sck changes level.
module spi_sck_gen #(
    parameter int CLKDIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sck_q, sck_d;
    logic             wrap;

    always_comb begin
        wrap  = en && (div_q == DIV_LAST);
        div_d = '0;
        sck_d = 1'b0;
        // Disabled: hold SCK low and restart the half-period count.
        if (en) begin
            div_d = wrap ? '0 : div_q + 1'b1;
            sck_d = wrap ? ~sck_q : sck_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    assign sck       = sck_q;
    assign rise_tick = wrap && !sck_q;
    assign fall_tick = wrap && sck_q;

endmodule

// File: rtl/adc_spi_reader.sv
// Pulses AD_CONV, reads one 34-bit LTC1407A frame and returns both 14-bit
// samples with a single-cycle adc_done.
module adc_spi_reader
    import adc_pkg::*;
#(
    parameter int CLKDIV = 2
) (
    input  logic              CLK50MHZ,
    input  logic              RST,
    adc_spi_reader_if.slave   ctl,
    output logic              ad_conv,
    output logic              spi_sck,
    input  logic              spi_miso
);

    localparam int CONV_W = $clog2(2 * CLKDIV);
    localparam logic [CONV_W-1:0]    CONV_LAST = CONV_W'(2 * CLKDIV - 1);
    localparam logic [BIT_CNT_W-1:0] A_LO      = BIT_CNT_W'(A_FIRST);
    localparam logic [BIT_CNT_W-1:0] A_HI      = BIT_CNT_W'(A_FIRST + SAMPLE_W - 1);
    localparam logic [BIT_CNT_W-1:0] B_LO      = BIT_CNT_W'(B_FIRST);
    localparam logic [BIT_CNT_W-1:0] B_HI      = BIT_CNT_W'(B_FIRST + SAMPLE_W - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(FRAME_BITS - 1);

    state_t              state_q, state_d;
    logic [CONV_W-1:0]   conv_cnt_q, conv_cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0] sh_a_q, sh_a_d;
    logic [SAMPLE_W-1:0] sh_b_q, sh_b_d;
    logic [SAMPLE_W-1:0] adc_a_q, adc_a_d;
    logic [SAMPLE_W-1:0] adc_b_q, adc_b_d;

    logic sck_en;
    logic sck_rise;
    logic sck_fall;
    logic in_a;
    logic in_b;

    assign sck_en = (state_q == ST_SHIFT);

    spi_sck_gen #(
        .CLKDIV (CLKDIV)
    ) u_sck_gen (
        .clk       (CLK50MHZ),
        .rst_n     (RST),
        .en        (sck_en),
        .sck       (spi_sck),
        .rise_tick (sck_rise),
        .fall_tick (sck_fall)
    );

    assign in_a = (bit_cnt_q >= A_LO) && (bit_cnt_q <= A_HI);
    assign in_b = (bit_cnt_q >= B_LO) && (bit_cnt_q <= B_HI);

    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sh_a_d     = sh_a_q;
        sh_b_d     = sh_b_q;
        adc_a_d    = adc_a_q;
        adc_b_d    = adc_b_q;

        case (state_q)
            ST_IDLE: begin
                conv_cnt_d = '0;
                bit_cnt_d  = '0;
                if (ctl.adc_trig) begin
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_cnt_q == CONV_LAST) begin
                    state_d    = ST_SHIFT;
                    conv_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    conv_cnt_d = conv_cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                // bit_cnt holds the index of the current SCK period; it
                // advances on the falling edge so the rising-edge sample
                // sees a stable index.
                if (sck_rise) begin
                    if (in_a) begin
                        sh_a_d = {sh_a_q[SAMPLE_W-2:0], spi_miso};
                    end
                    if (in_b) begin
                        sh_b_d = {sh_b_q[SAMPLE_W-2:0], spi_miso};
                    end
                end
                if (sck_fall) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_DONE;
                        adc_a_d = sh_a_q;
                        adc_b_d = sh_b_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            conv_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sh_a_q     <= '0;
            sh_b_q     <= '0;
            adc_a_q    <= '0;
            adc_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_a_q     <= sh_a_d;
            sh_b_q     <= sh_b_d;
            adc_a_q    <= adc_a_d;
            adc_b_q    <= adc_b_d;
        end
    end

    assign ad_conv      = (state_q == ST_CONV);
    assign ctl.busy     = (state_q != ST_IDLE);
    assign ctl.adc_done = (state_q == ST_DONE);
    assign ctl.adc_a    = adc_a_q;
    assign ctl.adc_b    = adc_b_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: one CLKDIV=2 and one CLKDIV=1 instance,
// each fed by a behavioural LTC1407A frame model.
module tb_adc_spi_reader;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    int n_cmp = 0;
    int n_bad = 0;

    adc_spi_reader_if if0 ();
    adc_spi_reader_if if1 ();

    logic conv0, sck0, miso0;
    logic conv1, sck1, miso1;

    logic [33:0] frame0 = '0;
    logic [33:0] frame1 = '0;
    logic [33:0] sh0 = '0;
    logic [33:0] sh1 = '0;

    int conv0_cnt = 0, rise0_cnt = 0, done0_cnt = 0;
    int conv1_cnt = 0, rise1_cnt = 0, done1_cnt = 0;
    logic conv0_prev = 1'b0, sck0_prev = 1'b0;
    logic conv1_prev = 1'b0, sck1_prev = 1'b0;

    adc_spi_reader #(.CLKDIV(2)) dut0 (
        .CLK50MHZ (clk),
        .RST      (rst_n),
        .ctl      (if0),
        .ad_conv  (conv0),
        .spi_sck  (sck0),
        .spi_miso (miso0)
    );

    adc_spi_reader #(.CLKDIV(1)) dut1 (
        .CLK50MHZ (clk),
        .RST      (rst_n),
        .ctl      (if1),
        .ad_conv  (conv1),
        .spi_sck  (sck1),
        .spi_miso (miso1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    assign miso0 = sh0[33];
    assign miso1 = sh1[33];

    // ADC model and event counters: frame loads on AD_CONV rise, next bit
    // appears after each SCK fall.
    always @(negedge clk) begin
        if (conv0) conv0_cnt = conv0_cnt + 1;
        if (sck0 && !sck0_prev) rise0_cnt = rise0_cnt + 1;
        if (if0.adc_done) done0_cnt = done0_cnt + 1;
        if (conv0 && !conv0_prev) sh0 = frame0;
        else if (!sck0 && sck0_prev) sh0 = {sh0[32:0], 1'b0};
        conv0_prev = conv0;
        sck0_prev  = sck0;

        if (conv1) conv1_cnt = conv1_cnt + 1;
        if (sck1 && !sck1_prev) rise1_cnt = rise1_cnt + 1;
        if (if1.adc_done) done1_cnt = done1_cnt + 1;
        if (conv1 && !conv1_prev) sh1 = frame1;
        else if (!sck1 && sck1_prev) sh1 = {sh1[32:0], 1'b0};
        conv1_prev = conv1;
        sck1_prev  = sck1;
    end

    function automatic logic [33:0] mk(input logic [13:0] a, input logic [13:0] b,
                                       input logic [1:0] d);
        return {d, a, d, b, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int which, input int limit, output int at, output int busy_low);
        logic d;
        logic b;
        at = -1;
        busy_low = 0;
        for (int i = 0; i < limit; i++) begin
            step();
            d = (which == 0) ? if0.adc_done : if1.adc_done;
            b = (which == 0) ? if0.busy : if1.busy;
            if (d) begin
                at = cyc;
                break;
            end
            if (!b) busy_low++;
        end
        check("done_seen", (at >= 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    int r, at, t1, bl, bc, br, bd, k;

    initial begin
        // Reset held with trigger high: nothing may start.
        rst_n = 1'b0;
        if0.adc_trig = 1'b1;
        if1.adc_trig = 1'b0;
        frame0 = mk(14'h1FFF, 14'h2000, 2'b11);
        frame1 = mk(14'h3FFF, 14'h0000, 2'b11);
        bc = conv0_cnt;
        repeat (3) step();
        check("rst_done", 32'(if0.adc_done), 32'd0);
        check("rst_a", 32'(if0.adc_a), 32'd0);
        check("rst_b", 32'(if0.adc_b), 32'd0);
        check("rst_busy", 32'(if0.busy), 32'd0);
        check("rst_conv", 32'(conv0), 32'd0);
        check("rst_sck", 32'(sck0), 32'd0);
        check("rst_conv_cycles", 32'(conv0_cnt - bc), 32'd0);
        $display("reset: held 3 cycles with trig high");

        // Single conversion started by release of reset.
        bc = conv0_cnt; br = rise0_cnt;
        r = cyc;
        rst_n = 1'b1;
        step();
        check("start_conv", 32'(conv0), 32'd1);
        check("start_busy", 32'(if0.busy), 32'd1);
        if0.adc_trig = 1'b0;
        wait_done(0, 300, at, bl);
        check("single_latency", 32'(at - r), 32'd141);
        check("single_a", 32'(if0.adc_a), 32'h1FFF);
        check("single_b", 32'(if0.adc_b), 32'h2000);
        check("single_conv_cycles", 32'(conv0_cnt - bc), 32'd4);
        check("single_sck_rises", 32'(rise0_cnt - br), 32'd34);
        step();
        check("single_done_width", 32'(if0.adc_done), 32'd0);
        check("single_idle_busy", 32'(if0.busy), 32'd0);
        check("single_hold_a", 32'(if0.adc_a), 32'h1FFF);
        $display("single: a=%h b=%h latency=%0d", if0.adc_a, if0.adc_b, at - r);

        // Trigger while busy is dropped.
        frame0 = mk(14'h0123, 14'h3210, 2'b11);
        bd = done0_cnt;
        step();
        r = cyc;
        if0.adc_trig = 1'b1;
        step();
        if0.adc_trig = 1'b0;
        repeat (48) step();
        if0.adc_trig = 1'b1;
        step();
        if0.adc_trig = 1'b0;
        wait_done(0, 300, at, bl);
        check("busy_latency", 32'(at - r), 32'd141);
        check("busy_never_low", 32'(bl), 32'd0);
        check("busy_a", 32'(if0.adc_a), 32'h0123);
        check("busy_b", 32'(if0.adc_b), 32'h3210);
        repeat (200) step();
        check("busy_done_count", 32'(done0_cnt - bd), 32'd1);
        check("busy_idle", 32'(if0.busy), 32'd0);
        $display("trig_while_busy: dones=%0d", done0_cnt - bd);

        // Back-to-back with trigger held high.
        frame0 = mk(14'h0001, 14'h3FFE, 2'b11);
        bd = done0_cnt;
        step();
        r = cyc;
        if0.adc_trig = 1'b1;
        wait_done(0, 300, t1, bl);
        check("b2b_latency", 32'(t1 - r), 32'd141);
        check("b2b1_a", 32'(if0.adc_a), 32'h0001);
        check("b2b1_b", 32'(if0.adc_b), 32'h3FFE);
        frame0 = mk(14'h2AAA, 14'h1555, 2'b11);
        repeat (70) step();
        check("b2b_hold_a", 32'(if0.adc_a), 32'h0001);
        check("b2b_hold_b", 32'(if0.adc_b), 32'h3FFE);
        check("b2b_mid_busy", 32'(if0.busy), 32'd1);
        wait_done(0, 300, at, bl);
        if0.adc_trig = 1'b0;
        check("b2b_spacing", 32'(at - t1), 32'd142);
        check("b2b2_a", 32'(if0.adc_a), 32'h2AAA);
        check("b2b2_b", 32'(if0.adc_b), 32'h1555);
        repeat (200) step();
        check("b2b_done_count", 32'(done0_cnt - bd), 32'd2);
        check("b2b_idle", 32'(if0.busy), 32'd0);
        $display("back_to_back: spacing=%0d a=%h b=%h", at - t1, if0.adc_a, if0.adc_b);

        // Reset in the middle of SHIFT.
        frame0 = mk(14'h1234, 14'h0F0F, 2'b11);
        br = rise0_cnt;
        if0.adc_trig = 1'b1;
        step();
        if0.adc_trig = 1'b0;
        k = 0;
        while ((rise0_cnt - br) < 10 && k < 200) begin
            step();
            k++;
        end
        check("mid_reached_bit10", 32'(rise0_cnt - br), 32'd10);
        rst_n = 1'b0;
        step();
        check("mid_rst_sck", 32'(sck0), 32'd0);
        check("mid_rst_busy", 32'(if0.busy), 32'd0);
        check("mid_rst_a", 32'(if0.adc_a), 32'd0);
        check("mid_rst_b", 32'(if0.adc_b), 32'd0);
        check("mid_rst_conv", 32'(conv0), 32'd0);
        rst_n = 1'b1;
        step();
        frame0 = mk(14'h0ABC, 14'h3C3C, 2'b11);
        r = cyc;
        if0.adc_trig = 1'b1;
        step();
        if0.adc_trig = 1'b0;
        wait_done(0, 300, at, bl);
        check("post_rst_latency", 32'(at - r), 32'd141);
        check("post_rst_a", 32'(if0.adc_a), 32'h0ABC);
        check("post_rst_b", 32'(if0.adc_b), 32'h3C3C);
        $display("mid_frame_reset: a=%h b=%h", if0.adc_a, if0.adc_b);

        // CLKDIV=1 instance.
        bc = conv1_cnt; br = rise1_cnt;
        step();
        r = cyc;
        if1.adc_trig = 1'b1;
        step();
        if1.adc_trig = 1'b0;
        wait_done(1, 200, at, bl);
        check("div1_latency", 32'(at - r), 32'd71);
        check("div1_a", 32'(if1.adc_a), 32'h3FFF);
        check("div1_b", 32'(if1.adc_b), 32'h0000);
        check("div1_conv_cycles", 32'(conv1_cnt - bc), 32'd2);
        check("div1_sck_rises", 32'(rise1_cnt - br), 32'd34);
        $display("clkdiv1: a=%h b=%h latency=%0d", if1.adc_a, if1.adc_b, at - r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
